lut_fifo64x8: RTL and testbench
===============================

LUT_FIFO64X8 -- requirements
Module: lut_fifo64x8

Interface
REQ-001 Parameter: none; width fixed at 8 bits, depth fixed at 64 entries.
REQ-002 clk        input   1  single clock; all state changes on rising edge.
REQ-003 rst        input   1  asynchronous, active-high reset.
REQ-004 clear      input   1  synchronous flush; discards all stored entries.
REQ-005 in_data    input   8  write data.
REQ-006 in_valid   input   1  producer offers in_data.
REQ-007 in_ready   output  1  FIFO can accept; transfer when in_valid & in_ready at rising edge.
REQ-008 out_data   output  8  head entry, registered.
REQ-009 out_valid  output  1  out_data holds a valid head entry.
REQ-010 out_ready  input   1  consumer takes head; pop when out_valid & out_ready at rising edge.
REQ-011 count      output  7  total entries held (RAM plus output register), 0..64.

Function
REQ-012 Storage: 64x8 dual-port distributed RAM (one write port, one asynchronous read port) plus one 8-bit output register; RAM is not reset.
REQ-013 Write pointer wp[5:0], read pointer rp[5:0]; both wrap 63 -> 0 modulo 64.
REQ-014 Push: on accepted transfer, in_data written at RAM[wp], wp increments.
REQ-015 in_ready = (count < 64) & !clear; combinational from registered state and clear only, never from in_valid.
REQ-016 ram_count = count - out_valid; output register loads RAM[rp] and rp increments when ram_count > 0 and (out_valid == 0 or pop this cycle).
REQ-017 No write-to-output bypass: a word accepted at edge N is earliest out_valid after edge N+1 (2-edge latency through an empty FIFO).
REQ-018 Pop with ram_count == 0: out_valid falls to 0 on the same edge; out_data holds its last value.
REQ-019 count next = count + push - pop; simultaneous push and pop leaves count unchanged.
REQ-020 Full (count == 64): in_ready low; a same-cycle pop does not raise in_ready until the following cycle.
REQ-021 Empty (count == 0): out_valid low; out_ready ignored.
REQ-022 out_data and out_valid do not change while out_valid & !out_ready (stall holds head stable).
REQ-023 clear high at an edge: wp, rp, count set to 0 and out_valid set to 0; any push or pop in that cycle is discarded; clear takes priority over push and pop.
REQ-024 Order is strict FIFO; no entry is duplicated or dropped across pointer wrap.

Reset
REQ-025 rst high asserts immediately, independent of clk: wp = 0, rp = 0, count = 0, out_valid = 0, out_data = 8'h00, in_ready = 1 once rst is low and clear is low.
REQ-026 Reset mid-operation discards all contents; first word accepted after reset release is the first word presented.
REQ-027 Deassertion is synchronised by the integrator; the block requires no transfer attempt on the first edge after rst falls.

Verification
REQ-028 Single word: empty FIFO, push 8'hA5 at edge 0, out_ready=1 -> out_valid=1, out_data=8'hA5 after edge 1; count=1 after edge 0, 0 after the pop edge.
REQ-029 Fill: push 0..63 with out_ready=0 -> count=64, in_ready=0, 65th push not accepted; then drain -> data 0..63 in order, count returns to 0, out_valid=0.
REQ-030 Wrap: 200 words of incrementing data with random in_valid/out_ready -> output sequence identical to input, count always equals pushes minus pops, never >64.
REQ-031 Simultaneous at full: count=64, pop and attempted push same cycle -> push rejected, count=63; next cycle in_ready=1.
REQ-032 Clear: 10 words held, clear pulsed with in_valid=1 -> count=0, out_valid=0, pushed word discarded; next push 8'h3C appears as head after 2 edges.
REQ-033 Async reset: assert rst between edges with 5 words held -> out_valid=0, count=0, out_data=8'h00 before next edge; no stale word emerges afterwards.

Source files
------------

// File: rtl/lut_fifo64x8.sv
// lut_fifo64x8: 64x8 FIFO built from distributed RAM plus a registered head word
module lut_fifo64x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] count
);
    logic [7:0] mem [64];
    logic [5:0] wp;
    logic [5:0] rp;
    logic [6:0] ram_count;
    logic       push;
    logic       pop;
    logic       load;

    // count[6] is set only at exactly 64 entries, so it doubles as the full flag
    assign in_ready  = !count[6] && !clear;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ram_count = count - {6'd0, out_valid};
    // refill the head register whenever it is empty or being consumed and RAM has data
    assign load      = (ram_count != 7'd0) && (!out_valid || pop);

    // RAM write port; contents are never reset, pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_data;
    end

    // pointers, occupancy and head register; clear overrides any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= 6'd0;
            rp        <= 6'd0;
            count     <= 7'd0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (clear) begin
            wp        <= 6'd0;
            rp        <= 6'd0;
            count     <= 7'd0;
            out_valid <= 1'b0;
        end else begin
            if (push) wp <= wp + 6'd1;
            if (load) begin
                out_data <= mem[rp];
                rp       <= rp + 6'd1;
            end
            out_valid <= load || (out_valid && !pop);
            count     <= count + {6'd0, push} - {6'd0, pop};
        end
    end
endmodule

// File: tb/tb_lut_fifo64x8.sv
// tb_lut_fifo64x8: directed vector table plus hand sequences for fill, wrap, clear and reset
module tb_lut_fifo64x8;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       clr;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic [6:0] cnt;
        logic       ov;
        logic [7:0] od;
        logic       ir;
    } vec_t;

    vec_t vecs [15];

    lut_fifo64x8 dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic iv, input logic [7:0] d, input logic ordy);
        clear = c;
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
    endtask

    initial begin
        int sent;
        int recv;
        int mcount;
        int cyc;
        logic iv;
        logic ordy;
        logic pop;

        // clr iv data ordy | count ov out_data in_ready (sampled after the edge, inputs still applied)
        vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 7'd1, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd1, 1'b1, 8'hA5, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b0, 8'hA5, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, 7'd1, 1'b0, 8'hA5, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 7'd2, 1'b1, 8'h11, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h33, 1'b0, 7'd3, 1'b1, 8'h11, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 7'd3, 1'b1, 8'h11, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h44, 1'b1, 7'd3, 1'b1, 8'h22, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd2, 1'b1, 8'h33, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd1, 1'b1, 8'h44, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b0, 8'h44, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b0, 8'h44, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h55, 1'b1, 7'd1, 1'b0, 8'h44, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 8'h66, 1'b1, 7'd0, 1'b0, 8'h44, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b0, 8'h44, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        chk("reset count", 32'(count), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'h00);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            step();
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
        end

        // fill to 64 with the consumer stalled
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            step();
        end
        chk("full count", 32'(count), 32'd64);
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full head", 32'(out_data), 32'h00);
        drive(1'b0, 1'b1, 8'hEE, 1'b0);
        step();
        chk("65th push rejected", 32'(count), 32'd64);
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        #1;
        chk("full pop in_ready same cycle", 32'(in_ready), 32'd0);
        step();
        chk("full pop count", 32'(count), 32'd63);
        chk("full pop in_ready next", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int k = 1; k < 64; k++) begin
            chk($sformatf("drain valid %0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain data %0d", k), 32'(out_data), 32'(k));
            step();
        end
        chk("drain count", 32'(count), 32'd0);
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // 200 words through with random handshakes, pointers wrap several times
        sent = 0;
        recv = 0;
        mcount = 0;
        cyc = 0;
        while ((sent < 200 || recv < sent) && cyc < 5000) begin
            iv = (sent < 200) && ($urandom_range(0, 3) != 0);
            ordy = (cyc % 400 < 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            drive(1'b0, iv, 8'(sent), ordy);
            #1;
            chk("wrap in_ready", 32'(in_ready), 32'(mcount < 64));
            pop = out_valid && ordy;
            if (pop) chk("wrap data", 32'(out_data), 32'(recv[7:0]));
            step();
            if (iv && mcount < 64) begin
                sent++;
                mcount++;
            end
            if (pop) begin
                recv++;
                mcount--;
            end
            chk("wrap count", 32'(count), 32'(mcount));
            cyc++;
        end
        chk("wrap all words received", 32'(recv), 32'd200);

        // clear with 10 words held and a push attempted in the same cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
            step();
        end
        chk("pre-clear count", 32'(count), 32'd10);
        drive(1'b1, 1'b1, 8'h99, 1'b1);
        step();
        chk("clear count", 32'(count), 32'd0);
        chk("clear out_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        step();
        chk("post-clear push count", 32'(count), 32'd1);
        chk("post-clear latency", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("post-clear head valid", 32'(out_valid), 32'd1);
        chk("post-clear head data", 32'(out_data), 32'h3C);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        chk("post-clear drained", 32'(count), 32'd0);

        // asynchronous reset between edges with 5 words held
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        step();
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("post-rst head data", 32'(out_data), 32'h77);
        chk("post-rst count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        step();
        chk("post-rst no stale valid", 32'(out_valid), 32'd0);
        chk("post-rst no stale count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
